// File: rtl/vco_ramp_ctrl_if.sv
// VCO ramp controller bus: register-block controls in, tuning code and status out.
// Optional VCO_RAMP_LIMIT_EN adds the CODE_MIN/CODE_MAX window inputs.
interface vco_ramp_ctrl_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] VCO_SEL;
  logic [7:0]       rampTime;
  logic             LOAD;
  logic             Vup;
  logic             Vdn;
  logic             PD;
  logic [WIDTH-1:0] VCO_CODE;
  logic             BUSY;
  logic             DONE;
`ifdef VCO_RAMP_LIMIT_EN
  logic [WIDTH-1:0] CODE_MIN;
  logic [WIDTH-1:0] CODE_MAX;

  modport master (output VCO_SEL, rampTime, LOAD, Vup, Vdn, PD, CODE_MIN, CODE_MAX,
                  input  VCO_CODE, BUSY, DONE);
  modport slave  (input  VCO_SEL, rampTime, LOAD, Vup, Vdn, PD, CODE_MIN, CODE_MAX,
                  output VCO_CODE, BUSY, DONE);
`else
  modport master (output VCO_SEL, rampTime, LOAD, Vup, Vdn, PD,
                  input  VCO_CODE, BUSY, DONE);
  modport slave  (input  VCO_SEL, rampTime, LOAD, Vup, Vdn, PD,
                  output VCO_CODE, BUSY, DONE);
`endif
endinterface

// File: rtl/vco_ramp_ctrl.sv
// VCO tuning-code slew controller. Moves VCO_CODE one LSB per rampTime*PRESCALE
// cycles toward the latched target, with idle-time manual trim and power-down.
// Optional feature macro: VCO_RAMP_LIMIT_EN (clamps target/trim into CODE_MIN..CODE_MAX).
module vco_ramp_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 16
) (
  input  logic            CLK,
  input  logic            reset_n,
  vco_ramp_ctrl_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, RAMP, PDN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [7:0]       rt_q, rt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             vup_q, vdn_q;

  logic [WIDTH-1:0] lo, hi, sel_c;
  logic             up_e, dn_e, tick;

`ifdef VCO_RAMP_LIMIT_EN
  assign lo = bus.CODE_MIN;
  assign hi = bus.CODE_MAX;
`else
  assign lo = '0;
  assign hi = '1;
`endif

  // Clamp the requested target; upper bound applied last so it wins on an inverted window
  always_comb begin
    sel_c = bus.VCO_SEL;
    if (sel_c < lo) sel_c = lo;
    if (sel_c > hi) sel_c = hi;
  end

  assign up_e = bus.Vup & ~vup_q;
  assign dn_e = bus.Vdn & ~vdn_q;
  assign tick = (pre_q == PW'(PRESCALE - 1));

  // Next-state: power-down overrides everything, LOAD restarts timing, trim only when idle
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    rt_d    = rt_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (bus.PD) begin
      state_d = PDN;
      code_d  = '0;
      pre_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PDN: state_d = IDLE;
        default: begin
          if (bus.LOAD) begin
            tgt_d = sel_c;
            rt_d  = bus.rampTime;
            pre_d = '0;
            cnt_d = '0;
            if (sel_c == code_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (bus.rampTime == 8'd0) begin
              code_d  = sel_c;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RAMP;
            end
          end else if (state_q == IDLE) begin
            if (up_e && !dn_e && code_q < hi)      code_d = code_q + 1'b1;
            else if (dn_e && !up_e && code_q > lo) code_d = code_q - 1'b1;
          end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
              if (cnt_q == rt_q - 8'd1) begin
                cnt_d  = '0;
                // direction re-evaluated every step so the code cannot overshoot
                code_d = (tgt_q > code_q) ? code_q + 1'b1 : code_q - 1'b1;
                if (code_d == tgt_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      tgt_q   <= '0;
      rt_q    <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      vup_q   <= 1'b0;
      vdn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      rt_q    <= rt_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      vup_q   <= bus.Vup;
      vdn_q   <= bus.Vdn;
    end
  end

  assign bus.VCO_CODE = code_q;
  assign bus.BUSY     = (state_q == RAMP);
  assign bus.DONE     = done_q;
endmodule

// File: tb/tb_vco_ramp_ctrl.sv
// Directed bench for vco_ramp_ctrl with PRESCALE=4: single-cycle vector table
// plus hand-written ramp, retarget, power-down and async-reset sequences.
module tb_vco_ramp_ctrl;
  localparam int W = 8;
  localparam int P = 4;

  logic CLK = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   dones;

  vco_ramp_ctrl_if #(.WIDTH(W)) bus ();

  vco_ramp_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    bit         load;
    logic [7:0] sel;
    logic [7:0] rt;
    bit         vup, vdn, pd;
    logic [7:0] code;
    bit         busy, done;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit load, input logic [7:0] sel, input logic [7:0] rt,
                       input bit vup, input bit vdn, input bit pd);
    bus.LOAD = load; bus.VCO_SEL = sel; bus.rampTime = rt;
    bus.Vup = vup; bus.Vdn = vdn; bus.PD = pd;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk3(input string nm, input int code, input int busy, input int done);
    chk({nm, ".code"}, int'(bus.VCO_CODE), code);
    chk({nm, ".busy"}, int'(bus.BUSY), busy);
    chk({nm, ".done"}, int'(bus.DONE), done);
  endtask

  task automatic apply(input vec_t v);
    drive(v.load, v.sel, v.rt, v.vup, v.vdn, v.pd);
    cyc();
    chk3(v.name, int'(v.code), int'(v.busy), int'(v.done));
  endtask

  initial begin
    //          name        ld  sel   rt  up dn pd  code busy done
    tbl[0]  = '{"rt0_jump",  1, 8'd2,   0, 0, 0, 0, 8'd2,   0, 1};
    tbl[1]  = '{"rt0_after", 0, 8'd0,   0, 0, 0, 0, 8'd2,   0, 0};
    tbl[2]  = '{"rt0_full",  1, 8'd255, 0, 0, 0, 0, 8'd255, 0, 1};
    tbl[3]  = '{"sat_up1",   0, 8'd0,   0, 1, 0, 0, 8'd255, 0, 0};
    tbl[4]  = '{"idle_a",    0, 8'd0,   0, 0, 0, 0, 8'd255, 0, 0};
    tbl[5]  = '{"sat_up2",   0, 8'd0,   0, 1, 0, 0, 8'd255, 0, 0};
    tbl[6]  = '{"idle_b",    0, 8'd0,   0, 0, 0, 0, 8'd255, 0, 0};
    tbl[7]  = '{"sat_up3",   0, 8'd0,   0, 1, 0, 0, 8'd255, 0, 0};
    tbl[8]  = '{"idle_c",    0, 8'd0,   0, 0, 0, 0, 8'd255, 0, 0};
    tbl[9]  = '{"trim_dn",   0, 8'd0,   0, 0, 1, 0, 8'd254, 0, 0};
    tbl[10] = '{"dn_level",  0, 8'd0,   0, 0, 0, 0, 8'd254, 0, 0};
    tbl[11] = '{"both_edge", 0, 8'd0,   0, 1, 1, 0, 8'd254, 0, 0};
    tbl[12] = '{"idle_d",    0, 8'd0,   0, 0, 0, 0, 8'd254, 0, 0};
    tbl[13] = '{"trim_up",   0, 8'd0,   0, 1, 0, 0, 8'd255, 0, 0};
    tbl[14] = '{"rt0_zero",  1, 8'd0,   0, 0, 0, 0, 8'd0,   0, 1};
    tbl[15] = '{"sat_dn",    0, 8'd0,   0, 0, 1, 0, 8'd0,   0, 0};
    tbl[16] = '{"idle_e",    0, 8'd0,   0, 0, 0, 0, 8'd0,   0, 0};
    tbl[17] = '{"same_tgt",  1, 8'd0,   3, 0, 0, 0, 8'd0,   0, 1};
    tbl[18] = '{"same_aft",  0, 8'd0,   0, 0, 0, 0, 8'd0,   0, 0};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
`ifdef VCO_RAMP_LIMIT_EN
    bus.CODE_MIN = 8'd0;
    bus.CODE_MAX = 8'd255;
`endif
    #23;
    chk3("reset", 0, 0, 0);
    reset_n = 1'b1;
    cyc();
    chk3("post_reset", 0, 0, 0);

    // 1: ramp 0->5, rampTime=1, one step every PRESCALE cycles
    drive(1, 8'd5, 8'd1, 0, 0, 0);
    cyc();
    chk3("t1_load", 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 21; k++) begin
      cyc();
      chk3($sformatf("t1_k%0d", k), k / P > 5 ? 5 : k / P, k < 20 ? 1 : 0, k == 20 ? 1 : 0);
    end

    // 2 and 4: rampTime=0 jumps and idle trim (table)
    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // 3: ramp 0->200 at rampTime=2, retarget to 10 at code 50
    drive(1, 8'd200, 8'd2, 0, 0, 0);
    cyc();
    chk3("t3_load", 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 400; k++) begin
      cyc();
      chk($sformatf("t3_up_k%0d", k), int'(bus.VCO_CODE), k / (2 * P));
    end
    drive(1, 8'd10, 8'd2, 0, 0, 0);
    cyc();
    chk3("t3_retarget", 50, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    dones = 0;
    for (int k = 1; k <= 330; k++) begin
      cyc();
      if (bus.DONE) dones++;
      chk($sformatf("t3_dn_k%0d", k), int'(bus.VCO_CODE), k >= 320 ? 10 : 50 - k / (2 * P));
      chk($sformatf("t3_busy_k%0d", k), int'(bus.BUSY), k < 320 ? 1 : 0);
    end
    chk("t3_done_count", dones, 1);

    // 5: power-down mid-ramp at code 37; LOAD and trim ignored while down
    drive(1, 8'd100, 8'd1, 0, 0, 0);
    cyc();
    chk3("t5_load", 10, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 108; k++) cyc();
    chk3("t5_at37", 37, 1, 0);
    drive(1, 8'd50, 8'd0, 0, 0, 1);
    cyc();
    chk3("t5_pd", 0, 0, 0);
    drive(1, 8'd50, 8'd0, 1, 0, 1);
    cyc();
    chk3("t5_pd_load", 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    chk3("t5_pd_exit", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk3("t5_no_queue", 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    cyc();
    chk3("t5_trim_ok", 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // 6: async reset between edges mid-ramp
    drive(1, 8'd50, 8'd1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) cyc();
    chk3("t6_ramp", 3, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk3("t6_async", 0, 0, 0);
    #3 reset_n = 1'b1;
    cyc();
    chk3("t6_after", 0, 0, 0);

`ifdef VCO_RAMP_LIMIT_EN
    bus.CODE_MAX = 8'd100;
    drive(1, 8'd180, 8'd1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    dones = 0;
    for (int k = 1; k <= 410; k++) begin
      cyc();
      if (bus.DONE) dones++;
    end
    chk3("lim_end", 100, 0, 0);
    chk("lim_done_count", dones, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
